// File: rtl/mem_wr_sched_pkg.sv
// Shared types and default widths for the register-file write-port scheduler.
package mem_wr_sched_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 1;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/mem_wr_arb2.sv
// Combinational 2-way write arbiter. MEM_WR_SCHED_RR_EN selects round-robin,
// otherwise requester A has fixed priority.
module mem_wr_arb2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic a_valid_i,
    input  logic b_valid_i,
    output logic a_ready_o,
    output logic b_ready_o
);

`ifdef MEM_WR_SCHED_RR_EN
    // rr_q set means B wins the next contended cycle
    logic rr_q, rr_d;

    always_comb begin
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        if (en_i) begin
            if (a_valid_i && b_valid_i) begin
                a_ready_o = ~rr_q;
                b_ready_o = rr_q;
            end else begin
                a_ready_o = a_valid_i;
                b_ready_o = b_valid_i;
            end
        end
        rr_d = rr_q;
        if (a_ready_o) begin
            rr_d = 1'b1;
        end else if (b_ready_o) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_i;

    always_comb begin
        a_ready_o = en_i & a_valid_i;
        b_ready_o = en_i & b_valid_i & ~a_valid_i;
    end
`endif

endmodule

// File: rtl/mem_wr_sched.sv
// Write-port scheduler: sweeps INIT_VAL into every entry after reset/clear, then
// arbitrates two requesters onto the registered write port. Option: MEM_WR_SCHED_RR_EN.
module mem_wr_sched
    import mem_wr_sched_pkg::*;
#(
    parameter int unsigned          ADDR_W   = DefAddrW,
    parameter int unsigned          DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              we0,
    output logic [ADDR_W-1:0] waddr0,
    output logic [DATA_W-1:0] din0,
    output logic              init_done
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we0_q, we0_d;
    logic [ADDR_W-1:0] waddr0_q, waddr0_d;
    logic [DATA_W-1:0] din0_q, din0_d;
    logic              arb_en;

    assign arb_en = (state_q == StRun) && !clear;

    mem_wr_arb2 u_arb (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (arb_en),
        .a_valid_i (a_valid),
        .b_valid_i (b_valid),
        .a_ready_o (a_ready),
        .b_ready_o (b_ready)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we0_d    = 1'b0;
        waddr0_d = waddr0_q;
        din0_d   = din0_q;
        unique case (state_q)
            StInit: begin
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q[ADDR_W]) begin
                    // All 2**ADDR_W entries written; MSB avoids aliasing at wrap
                    state_d = StRun;
                end else begin
                    we0_d    = 1'b1;
                    waddr0_d = cnt_q[ADDR_W-1:0];
                    din0_d   = INIT_VAL;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clear) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else if (a_ready) begin
                    we0_d    = 1'b1;
                    waddr0_d = a_addr;
                    din0_d   = a_data;
                end else if (b_ready) begin
                    we0_d    = 1'b1;
                    waddr0_d = b_addr;
                    din0_d   = b_data;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            we0_q    <= 1'b0;
            waddr0_q <= '0;
            din0_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we0_q    <= we0_d;
            waddr0_q <= waddr0_d;
            din0_q   <= din0_d;
        end
    end

    assign we0       = we0_q;
    assign waddr0    = waddr0_q;
    assign din0      = din0_q;
    assign init_done = (state_q == StRun);

endmodule

// File: tb/tb_mem_wr_sched.sv
// Self-checking bench for mem_wr_sched: directed sweep/clear/reset steps plus
// randomized requester traffic against a grant-order and memory-content model.
module tb_mem_wr_sched;

    localparam int AW = 8;
    localparam int DW = 1;
    localparam logic [DW-1:0] IV = '0;
`ifdef MEM_WR_SCHED_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, we0, init_done;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] din0;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: expected outputs, expected memory, who won the last grant
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] sink_mem  [256];
    bit            in_run = 1'b0;
    bit            last_b = 1'b1;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_waddr = '0;
    logic [DW-1:0] exp_din = '0;

    mem_wr_sched dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .we0       (we0),
        .waddr0    (waddr0),
        .din0      (din0),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Behaves like the downstream memory: captures whatever the port writes
    always @(posedge clk) begin
        if (we0 === 1'b1) sink_mem[waddr0] <= din0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".we0"}, 32'(we0), 32'(exp_we));
        chk({tag, ".waddr0"}, 32'(waddr0), 32'(exp_waddr));
        chk({tag, ".din0"}, 32'(din0), 32'(exp_din));
        chk({tag, ".init_done"}, 32'(init_done), 32'(in_run));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        in_run    = 1'b0;
        last_b    = 1'b1;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_din   = '0;
        check_out("reset");
        chk("reset.a_ready", 32'(a_ready), 32'd0);
        chk("reset.b_ready", 32'(b_ready), 32'd0);
        reset = 1'b0;
    endtask

    // Requesters stay valid during the sweep; they must never be accepted
    task automatic sweep_writes(input int n);
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("sweep.a_ready", 32'(a_ready), 32'd0);
            chk("sweep.b_ready", 32'(b_ready), 32'd0);
            tick();
            exp_we    = 1'b1;
            exp_waddr = AW'(i);
            exp_din   = IV;
            model_mem[i] = IV;
            check_out("sweep");
        end
    endtask

    task automatic sweep_end();
        chk("sweep_end.a_ready", 32'(a_ready), 32'd0);
        tick();
        exp_we = 1'b0;
        in_run = 1'b1;
        check_out("sweep_end");
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic run_cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                             input logic clr, output bit ga, output bit gb);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        clear   = clr;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (in_run && !clr) begin
            if (av && bv) begin
                ga = !RrEn || last_b;
                gb = !ga;
            end else begin
                ga = av;
                gb = bv;
            end
        end
        chk("arb.a_ready", 32'(a_ready), 32'(ga));
        chk("arb.b_ready", 32'(b_ready), 32'(gb));
        tick();
        clear = 1'b0;
        if (ga) begin
            exp_we = 1'b1; exp_waddr = aa; exp_din = ad; model_mem[aa] = ad; last_b = 1'b0;
        end else if (gb) begin
            exp_we = 1'b1; exp_waddr = ba; exp_din = bd; model_mem[ba] = bd; last_b = 1'b1;
        end else begin
            exp_we = 1'b0;
        end
        if (clr) in_run = 1'b0;
        check_out("run");
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++) begin
            chk(tag, 32'(sink_mem[i]), 32'(model_mem[i]));
        end
    endtask

    initial begin
        bit            ga, gb, pa, pb;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] da, db;

        // Reset then full sweep; init_done one cycle after the last write
        do_reset();
        sweep_writes(256);
        sweep_end();

        // Single requester A
        run_cycle(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, ga, gb);

        // Contention for four cycles
        repeat (4) run_cycle(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, ga, gb);
        run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ga, gb);

        // Same-address collision: loser retries, later write must stick
        run_cycle(1'b1, 8'h40, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, ga, gb);
        run_cycle(!ga, 8'h40, 1'b1, !gb, 8'h40, 1'b0, 1'b0, ga, gb);
        run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ga, gb);
        chk("collide.mem40", 32'(sink_mem[8'h40]), 32'(model_mem[8'h40]));

        // Randomized traffic; requesters hold their request until accepted
        pa = 1'b0; pb = 1'b0;
        ra = '0; rb = '0; da = '0; db = '0;
        for (int c = 0; c < 300; c++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1'b1; ra = AW'($urandom_range(0, 31)); da = DW'($urandom);
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1'b1; rb = AW'($urandom_range(0, 31)); db = DW'($urandom);
            end
            run_cycle(pa, ra, da, pb, rb, db, 1'b0, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ga, gb);
        check_mem("rand.mem");

        // clear in RUN blocks the pending grant and restarts the sweep
        run_cycle(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, ga, gb);
        sweep_writes(20);

        // clear mid-sweep restarts at address 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_init.init_done", 32'(init_done), 32'd0);
        sweep_writes(256);
        sweep_end();

        // reset while the sweep shows address 100
        run_cycle(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, ga, gb);
        sweep_writes(101);
        do_reset();
        sweep_writes(256);
        sweep_end();
        run_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h7e, 1'b1, 1'b0, ga, gb);
        run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ga, gb);
        check_mem("final.mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
